// File: rtl/uart_fifo_port.sv
// Memory-mapped 8N1 UART with TX/RX byte FIFOs for the FemtoRV32 IO page.
// Registered read data, no wait states; irq on RX data or any sticky error.

module uart_fifo_port_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset_button,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full,
  output logic       push_ok
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic [7:0]          mem [DEPTH];
  logic                pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
  end
endmodule

module uart_fifo_port #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic        clk,
  input  logic        reset_button,
  input  logic        sel,
  input  logic        reg_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_wstrb,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_rbusy,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  logic data_wr, data_rd, stat_wr, stat_rd;
  assign data_wr = sel & mem_wstrb & ~reg_addr;
  assign data_rd = sel & mem_rstrb & ~reg_addr;
  assign stat_wr = sel & mem_wstrb &  reg_addr;
  assign stat_rd = sel & mem_rstrb &  reg_addr;

  logic unused_wdata;
  assign unused_wdata = ^mem_wdata[31:8];
  assign mem_rbusy    = 1'b0;

  logic [7:0] tx_head, rx_head, rx_shift;
  logic       tx_empty, tx_full, tx_push_ok, tx_pop;
  logic       rx_empty, unused_rx_full, rx_push_ok, rx_push;

  uart_fifo_port_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk, .reset_button, .push(data_wr), .wdata(mem_wdata[7:0]), .pop(tx_pop),
    .head(tx_head), .empty(tx_empty), .full(tx_full), .push_ok(tx_push_ok)
  );

  uart_fifo_port_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk, .reset_button, .push(rx_push), .wdata(rx_shift), .pop(data_rd),
    .head(rx_head), .empty(rx_empty), .full(unused_rx_full), .push_ok(rx_push_ok)
  );

  // ---------------- transmitter ----------------
  tx_state_t     tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_shift, tx_shift_n;
  logic          tx_n;

  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx       <= tx_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + CW'(1);
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_pop     = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = tx_head;
          tx_state_n = TX_START;
        end
      end
      TX_START: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n   = '0;
        tx_bit_n   = '0;
        tx_state_n = TX_DATA;
      end
      TX_DATA: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n = '0;
        if (tx_bit == 3'd7) begin
          tx_state_n = TX_STOP;
        end else begin
          tx_bit_n   = tx_bit + 3'd1;
          tx_shift_n = {1'b0, tx_shift[7:1]};
        end
      end
      TX_STOP: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = tx_head;
          tx_state_n = TX_START;
        end else begin
          tx_state_n = TX_IDLE;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
    // The line level is registered from the next state so tx never glitches.
    unique case (tx_state_n)
      TX_START: tx_n = 1'b0;
      TX_DATA:  tx_n = tx_shift_n[0];
      default:  tx_n = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  rx_state_t     rx_state, rx_state_n;
  logic [1:0]    rx_sync;
  logic          rx_s, rx_prev;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_shift_n;
  logic          frame_err_set;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_sync  <= {rx_sync[0], rx};
      rx_prev  <= rx_s;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  always_comb begin
    rx_state_n    = rx_state;
    rx_cnt_n      = rx_cnt + CW'(1);
    rx_bit_n      = rx_bit;
    rx_shift_n    = rx_shift;
    rx_push       = 1'b0;
    frame_err_set = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_s) rx_state_n = RX_START;
      end
      RX_START: if (rx_cnt == BIT_HALF) begin
        rx_cnt_n   = '0;
        rx_bit_n   = '0;
        rx_state_n = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt == BIT_LAST) begin
        rx_cnt_n   = '0;
        rx_shift_n = {rx_s, rx_shift[7:1]};
        rx_bit_n   = rx_bit + 3'd1;
        if (rx_bit == 3'd7) rx_state_n = RX_STOP;
      end
      RX_STOP: if (rx_cnt == BIT_LAST) begin
        rx_cnt_n = '0;
        if (rx_s) begin
          rx_push    = 1'b1;
          rx_state_n = RX_IDLE;
        end else begin
          frame_err_set = 1'b1;
          rx_state_n    = RX_BREAK;
        end
      end
      RX_BREAK: begin
        rx_cnt_n = '0;
        if (rx_s) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------- sticky flags and bus ----------------
  logic rx_overrun, tx_drop, frame_err, tx_idle;
  logic [31:0] status_word, data_word;

  assign tx_idle     = tx_empty && (tx_state == TX_IDLE);
  assign status_word = {26'b0, frame_err, tx_drop, rx_overrun, tx_idle, tx_full, ~rx_empty};
  assign data_word   = rx_empty ? 32'd0 : {24'b0, rx_head};

  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) begin
      rx_overrun <= 1'b0;
      tx_drop    <= 1'b0;
      frame_err  <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      // Set has priority over a same-cycle clear.
      if (rx_push && !rx_push_ok)          rx_overrun <= 1'b1;
      else if (stat_wr && mem_wdata[3])    rx_overrun <= 1'b0;
      if (data_wr && !tx_push_ok)          tx_drop    <= 1'b1;
      else if (stat_wr && mem_wdata[4])    tx_drop    <= 1'b0;
      if (frame_err_set)                   frame_err  <= 1'b1;
      else if (stat_wr && mem_wdata[5])    frame_err  <= 1'b0;
      if (stat_rd)      mem_rdata <= status_word;
      else if (data_rd) mem_rdata <= data_word;
    end
  end

  assign irq = ~rx_empty | rx_overrun | tx_drop | frame_err;
endmodule
